// File: rtl/proc_host_pkg.sv
// Shared types for the processor-core host: FSM states and the data-memory request bundle.
package proc_host_pkg;
  localparam int MEM_AW = 8;

  typedef enum logic [2:0] {IDLE, LOAD, RUN, UNLOAD, DONE} state_t;

  typedef struct packed {
    logic              wr_en;
    logic [MEM_AW-1:0] addr;
    logic [7:0]        wdata;
  } mem_req_t;
endpackage

// File: rtl/mem_port_mux.sv
// 2:1 data-memory port select; the host owns the port whenever the core is held in reset.
module mem_port_mux
  import proc_host_pkg::*;
(
  input  logic     sel_host,
  input  mem_req_t host_req,
  input  mem_req_t core_req,
  output mem_req_t mem_req
);
  assign mem_req = sel_host ? host_req : core_req;
endmodule

// File: rtl/proc_host.sv
// Host initiator for the core run handshake: load operands, release core, wait done, unload results.
module proc_host
  import proc_host_pkg::*;
#(
  parameter logic [7:0] IN_BASE  = 8'h00,
  parameter int         IN_LEN   = 4,
  parameter logic [7:0] OUT_BASE = 8'h40,
  parameter int         OUT_LEN  = 4,
  parameter int         TIMEOUT  = 4096,
  parameter int         CW       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [7:0]        out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              finished,
  output logic              timeout_err,
  output logic [CW-1:0]     run_cycles,
  output logic              core_reset,
  input  logic              core_done,
  output logic              mem_wr_en,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);
  localparam logic [8:0]    IN_LAST  = 9'(IN_LEN - 1);
  localparam logic [8:0]    OUT_LAST = 9'(OUT_LEN - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] TO_VAL   = CW'(TIMEOUT);

  state_t        state;
  logic [8:0]    idx;
  logic [CW-1:0] cnt;
  mem_req_t      host_req, core_req, mem_req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      cnt         <= '0;
      finished    <= 1'b0;
      timeout_err <= 1'b0;
      run_cycles  <= '0;
    end else begin
      finished <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state       <= LOAD;
          idx         <= '0;
          timeout_err <= 1'b0;
        end
        LOAD: if (in_valid) begin
          if (idx == IN_LAST) begin
            state <= RUN;
            idx   <= '0;
            cnt   <= '0;
          end else begin
            idx <= idx + 9'd1;
          end
        end
        // done takes priority over an expiring cycle budget
        RUN: begin
          if (core_done) begin
            run_cycles <= cnt;
            state      <= UNLOAD;
          end else if (cnt == TO_LAST) begin
            timeout_err <= 1'b1;
            run_cycles  <= TO_VAL;
            state       <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        UNLOAD: if (out_ready) begin
          if (idx == OUT_LAST) state <= DONE;
          else                 idx   <= idx + 9'd1;
        end
        DONE: begin
          state    <= IDLE;
          finished <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy       = (state != IDLE);
  assign core_reset = (state != RUN);
  assign in_ready   = (state == LOAD);
  assign out_valid  = (state == UNLOAD);
  assign out_data   = mem_rdata;

  // Address holds through an unload stall, so out_data stays stable.
  always_comb begin
    host_req = '0;
    case (state)
      LOAD: begin
        host_req.wr_en = in_valid;
        host_req.addr  = IN_BASE + idx[7:0];
        host_req.wdata = in_data;
      end
      UNLOAD: host_req.addr = OUT_BASE + idx[7:0];
      default: host_req = '0;
    endcase
  end

  // The core drives memory on its own port; from this side the port parks idle while it runs.
  assign core_req = '0;

  mem_port_mux u_mux (
    .sel_host (core_reset),
    .host_req (host_req),
    .core_req (core_req),
    .mem_req  (mem_req)
  );

  assign mem_wr_en = mem_req.wr_en;
  assign mem_addr  = mem_req.addr;
  assign mem_wdata = mem_req.wdata;
endmodule

// File: tb/tb_proc_host.sv
// Self-checking bench: two hosts (in base 0x00 and 0xFE) in lockstep with a model core and memory.
module tb_proc_host;
  localparam int TO = 16;

  logic clk, reset, start, in_valid, out_ready;
  logic [7:0] in_data;
  logic [1:0] in_ready, out_valid, busy, finished, timeout_err, core_reset, core_done, mem_wr_en;
  logic [1:0][7:0] out_data, mem_addr, mem_wdata, mem_rdata;
  logic [1:0][15:0] run_cycles;

  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];
  logic [15:0] wq0[$];
  logic [15:0] wq1[$];
  int rc0, rc1, fin0, fin1, ov0, ov1;
  int core_d;
  int checks, failures;
  bit prev_to;

  proc_host #(.IN_BASE(8'h00), .TIMEOUT(TO)) u0 (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready[0]), .out_valid(out_valid[0]), .out_data(out_data[0]), .out_ready(out_ready),
    .busy(busy[0]), .finished(finished[0]), .timeout_err(timeout_err[0]), .run_cycles(run_cycles[0]),
    .core_reset(core_reset[0]), .core_done(core_done[0]), .mem_wr_en(mem_wr_en[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]));

  proc_host #(.IN_BASE(8'hFE), .TIMEOUT(TO)) u1 (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready[1]), .out_valid(out_valid[1]), .out_data(out_data[1]), .out_ready(out_ready),
    .busy(busy[1]), .finished(finished[1]), .timeout_err(timeout_err[1]), .run_cycles(run_cycles[1]),
    .core_reset(core_reset[1]), .core_done(core_done[1]), .mem_wr_en(mem_wr_en[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]));

  initial clk = 0;
  always #5 clk = ~clk;

  assign mem_rdata[0] = mem0[mem_addr[0]];
  assign mem_rdata[1] = mem1[mem_addr[1]];
  assign core_done[0] = !core_reset[0] && (rc0 >= core_d);
  assign core_done[1] = !core_reset[1] && (rc1 >= core_d);

  // Model core: result[k] = operand[k] ^ (0x3C + k), written while it runs.
  always @(posedge clk) begin
    if (mem_wr_en[0]) begin mem0[mem_addr[0]] <= mem_wdata[0]; wq0.push_back({mem_addr[0], mem_wdata[0]}); end
    if (mem_wr_en[1]) begin mem1[mem_addr[1]] <= mem_wdata[1]; wq1.push_back({mem_addr[1], mem_wdata[1]}); end
    if (!core_reset[0]) for (int k = 0; k < 4; k++) mem0[8'h40 + 8'(k)] <= mem0[8'h00 + 8'(k)] ^ (8'h3C + 8'(k));
    if (!core_reset[1]) for (int k = 0; k < 4; k++) mem1[8'h40 + 8'(k)] <= mem1[8'hFE + 8'(k)] ^ (8'h3C + 8'(k));
    rc0  <= core_reset[0] ? 0 : rc0 + 1;
    rc1  <= core_reset[1] ? 0 : rc1 + 1;
    fin0 <= fin0 + int'(finished[0]);
    fin1 <= fin1 + int'(finished[1]);
    ov0  <= ov0 + int'(out_valid[0]);
    ov1  <= ov1 + int'(out_valid[1]);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_core_reset"}, 32'(core_reset[i]), 1);
      chk({tag, "_busy"}, 32'(busy[i]), 0);
      chk({tag, "_finished"}, 32'(finished[i]), 0);
      chk({tag, "_in_ready"}, 32'(in_ready[i]), 0);
      chk({tag, "_out_valid"}, 32'(out_valid[i]), 0);
      chk({tag, "_mem_wr_en"}, 32'(mem_wr_en[i]), 0);
      chk({tag, "_timeout_err"}, 32'(timeout_err[i]), 0);
      chk({tag, "_run_cycles"}, 32'(run_cycles[i]), 0);
      chk({tag, "_mem_addr"}, 32'(mem_addr[i]), 0);
    end
  endtask

  task automatic run_txn(input logic [3:0][7:0] ops, input int d, input bit bub, input bit stl,
                         input int exp_rc, input bit exp_to, input bit abort2);
    int wb0, wb1, fb0, fb1, ob0, ob1, n, lc, rcnt, got, uc;
    logic [7:0] g0[$];
    logic [7:0] g1[$];
    logic [7:0] held, ea;
    bit stalled;
    core_d = d;
    wb0 = wq0.size(); wb1 = wq1.size();
    fb0 = fin0; fb1 = fin1; ob0 = ov0; ob1 = ov1;
    chk("timeout_sticky", 32'(timeout_err[0]), 32'(prev_to));
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0; #1;
    chk("start_busy", 32'(busy), 32'h3);
    chk("start_in_ready", 32'(in_ready), 32'h3);
    chk("start_clears_timeout", 32'(timeout_err), 0);
    n = 0; lc = 0;
    while (n < 4 && lc < 40) begin
      in_valid = bub ? (lc % 2 == 0) : 1'b1;
      in_data  = ops[n];
      #1;
      if (in_valid && in_ready[0]) n++;
      lc++;
      @(posedge clk); #1;
    end
    in_valid = 0; #1;
    chk("core_reset_fall", 32'(core_reset), 0);
    if (!bub) chk("load_cycles", 32'(lc), 4);
    chk("load_count0", 32'(wq0.size() - wb0), 4);
    chk("load_count1", 32'(wq1.size() - wb1), 4);
    for (int k = 0; k < 4; k++) begin
      ea = 8'h00 + 8'(k);
      chk("load_wr0", 32'(wq0[wb0 + k]), 32'({ea, ops[k]}));
      ea = 8'hFE + 8'(k);
      chk("load_wr1", 32'(wq1[wb1 + k]), 32'({ea, ops[k]}));
    end
    rcnt = 0;
    while (rcnt < 100 && busy[0] && !out_valid[0]) begin
      @(posedge clk); #1;
      start = (rcnt == 2 && d > 4);
      #1;
      if (rcnt == 3 && d > 5) begin
        chk("start_in_run_ignored_rst", 32'(core_reset), 0);
        chk("start_in_run_ignored_rdy", 32'(in_ready), 0);
      end
      rcnt++;
    end
    start = 0;
    if (rcnt >= 100) chk("run_bound", 0, 1);
    got = 0; uc = 0; stalled = 0; held = '0;
    while (got < 4 && uc < 60 && out_valid[0]) begin
      out_ready = stl ? 1'($urandom % 2) : 1'b1;
      #1;
      if (stalled) chk("stall_stable", 32'(out_data[0]), 32'(held));
      if (out_valid[0] && out_ready) g0.push_back(out_data[0]);
      if (out_valid[1] && out_ready) g1.push_back(out_data[1]);
      if (out_valid[0] && out_ready) got++;
      stalled = !out_ready;
      held = out_data[0];
      if (abort2 && got == 2) break;
      @(posedge clk); #2;
      uc++;
    end
    if (abort2) begin
      out_ready = 0;
      @(posedge clk); #1 reset = 1; #1;
      chk_reset_vals("abort");
      @(posedge clk); #1 reset = 0;
      prev_to = 0;
      return;
    end
    out_ready = 0;
    if (exp_to) begin
      chk("no_out_valid0", 32'(ov0 - ob0), 0);
      chk("no_out_valid1", 32'(ov1 - ob1), 0);
    end else begin
      chk("unload_count0", 32'(g0.size()), 4);
      chk("unload_count1", 32'(g1.size()), 4);
      for (int k = 0; k < 4 && k < g0.size() && k < g1.size(); k++) begin
        chk("unload_data0", 32'(g0[k]), 32'(ops[k] ^ (8'h3C + 8'(k))));
        chk("unload_data1", 32'(g1[k]), 32'(ops[k] ^ (8'h3C + 8'(k))));
      end
    end
    repeat (4) @(posedge clk);
    #2;
    chk("finished_once0", 32'(fin0 - fb0), 1);
    chk("finished_once1", 32'(fin1 - fb1), 1);
    chk("idle_busy", 32'(busy), 0);
    chk("run_cycles0", 32'(run_cycles[0]), 32'(exp_rc));
    chk("run_cycles1", 32'(run_cycles[1]), 32'(exp_rc));
    chk("timeout_err", 32'(timeout_err), exp_to ? 32'h3 : 32'h0);
    chk("no_extra_writes", 32'(wq0.size() - wb0), 4);
    prev_to = exp_to;
  endtask

  typedef struct {
    logic [3:0][7:0] ops;
    int d;
    bit bub;
    bit stl;
    int rc;
    bit to;
  } vec_t;

  initial begin
    vec_t vt[5];
    logic [3:0][7:0] rops;
    int rd;
    vt[0] = '{32'h44332211, 10, 1'b0, 1'b1, 10, 1'b0};
    vt[1] = '{32'h44332211, 10, 1'b1, 1'b0, 10, 1'b0};
    vt[2] = '{32'hD4C3B2A1, 99, 1'b0, 1'b0, 16, 1'b1};
    vt[3] = '{32'h0F1E2D3C, 15, 1'b1, 1'b1, 15, 1'b0};
    vt[4] = '{32'hFF0080AA, 0,  1'b0, 1'b1, 0,  1'b0};
    checks = 0; failures = 0; prev_to = 0; core_d = 1000;
    start = 0; in_valid = 0; in_data = 0; out_ready = 0;
    reset = 1;
    #3 chk_reset_vals("reset");
    repeat (2) @(posedge clk);
    #1 reset = 0;
    for (int v = 0; v < 5; v++)
      run_txn(vt[v].ops, vt[v].d, vt[v].bub, vt[v].stl, vt[v].rc, vt[v].to, 1'b0);
    run_txn(32'h87654321, 6, 1'b0, 1'b0, 6, 1'b0, 1'b1);
    run_txn(32'h13579BDF, 7, 1'b0, 1'b1, 7, 1'b0, 1'b0);
    for (int r = 0; r < 8; r++) begin
      rops = $urandom;
      rd = $urandom_range(0, 20);
      run_txn(rops, rd, 1'($urandom % 2), 1'($urandom % 2), (rd < TO) ? rd : TO, rd >= TO, 1'b0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
